jk_ff: RTL and testbench

JK_FF -- requirements
Module: jk_ff

---
 rtl/jk_ff.sv | 45 ++++
 tb/tb_jk_ff.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/jk_ff.sv
// jk_ff: WIDTH independent JK flip-flop cells sharing one clock.
// Q is registered. Qb is the combinational complement of Q.
// rst is synchronous and active-high, and it overrides j/k on the same edge.
module jk_ff #(
    parameter int                WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb
);

    logic [WIDTH-1:0] q_next;

    // Per-bit JK next-state decode; bits never look at each other.
    always_comb begin
        // NOTE: default assignment first so every path drives q_next (no latch).
        q_next = Q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({j[i], k[i]})
                2'b00:   q_next[i] = Q[i];
                2'b01:   q_next[i] = 1'b0;
                2'b10:   q_next[i] = 1'b1;
                2'b11:   q_next[i] = ~Q[i];
                default: q_next[i] = Q[i];
            endcase
        end
    end

    // State register: synchronous reset has priority over the JK update.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so all cells update together at the edge.
        if (rst) begin
            Q <= RST_VAL;
        end else begin
            Q <= q_next;
        end
    end

    assign Qb = ~Q;

endmodule

// File: tb/tb_jk_ff.sv
// Testbench for jk_ff. It uses one WIDTH=1 instance with the default reset value
// and one WIDTH=4 instance with RST_VAL=4'b1010.
// Each step pushes the expected Q into a scoreboard when the stimulus is driven.
// After the rising edge the entry is popped and compared with Q and Qb.
module tb_jk_ff;

    logic       clk;
    logic       rst1, j1, k1, q1, qb1;
    logic       rst4;
    logic [3:0] j4, k4, q4, qb4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        bit         wide;
        logic [3:0] q;
    } exp_t;

    exp_t sb[$];

    jk_ff #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst1), .j(j1), .k(k1), .Q(q1), .Qb(qb1)
    );

    jk_ff #(.WIDTH(4), .RST_VAL(4'b1010)) dut4 (
        .clk(clk), .rst(rst4), .j(j4), .k(k4), .Q(q4), .Qb(qb4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input bit wide, input logic [3:0] q);
        exp_t e;
        e.tag  = tag;
        e.wide = wide;
        e.q    = q;
        sb.push_back(e);
    endtask

    // Wait for the rising edge, then compare every pending entry away from the edge.
    task automatic edge_and_compare();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.wide) begin
                check({e.tag, "_q"},  q4,  e.q);
                check({e.tag, "_qb"}, qb4, ~e.q);
            end else begin
                check({e.tag, "_q"},  {3'b000, q1},  {3'b000, e.q[0]});
                check({e.tag, "_qb"}, {3'b000, qb1}, {3'b000, ~e.q[0]});
            end
        end
    endtask

    task automatic step1(input logic r, input logic jj, input logic kk,
                         input logic eq, input string tag);
        @(negedge clk);
        rst1 = r; j1 = jj; k1 = kk;
        push(tag, 1'b0, {3'b000, eq});
        edge_and_compare();
    endtask

    task automatic step4(input logic r, input logic [3:0] jj, input logic [3:0] kk,
                         input logic [3:0] eq, input string tag);
        @(negedge clk);
        rst4 = r; j4 = jj; k4 = kk;
        push(tag, 1'b1, eq);
        edge_and_compare();
    endtask

    // Sequence of (j,k) pairs applied from Q=0, with Q expected after each edge.
    logic [1:0] seq_jk [8] = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00};
    logic       seq_q  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [3:0] m;
        logic [3:0] rj, rk;
        logic       rr;

        rst1 = 1'b1; j1 = 1'b0; k1 = 1'b0;
        rst4 = 1'b1; j4 = 4'b0000; k4 = 4'b0000;

        // Reset, then hold.
        step1(1'b1, 1'b0, 1'b0, 1'b0, "reset");
        step1(1'b0, 1'b0, 1'b0, 1'b0, "hold_after_reset");

        // Mixed JK sequence.
        for (int i = 0; i < 8; i++) begin
            step1(1'b0, seq_jk[i][1], seq_jk[i][0], seq_q[i], $sformatf("seq%0d", i));
        end

        // Toggle run from Q=0.
        step1(1'b0, 1'b0, 1'b1, 1'b0, "clear_before_toggle");
        for (int i = 0; i < 4; i++) begin
            step1(1'b0, 1'b1, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, $sformatf("toggle%0d", i));
        end

        // Reset priority over set and over toggle, held for several edges.
        step1(1'b0, 1'b1, 1'b0, 1'b1, "set_before_rst");
        step1(1'b1, 1'b1, 1'b0, 1'b0, "rst_over_set");
        for (int i = 0; i < 3; i++) begin
            step1(1'b1, 1'b1, 1'b1, 1'b0, $sformatf("rst_over_toggle%0d", i));
        end
        // The first edge after reset releases uses the j/k sampled at that edge.
        step1(1'b0, 1'b1, 1'b1, 1'b1, "release_toggle");

        // A glitch on j between edges must not reach Q.
        step1(1'b0, 1'b0, 1'b1, 1'b0, "clear_before_glitch");
        @(negedge clk);
        j1 = 1'b0; k1 = 1'b0;
        push("glitch", 1'b0, 4'b0000);
        #2 j1 = 1'b1;
        #1 j1 = 1'b0;
        edge_and_compare();

        // Wide instance with a nonzero reset value.
        step4(1'b1, 4'b1111, 4'b1111, 4'b1010, "w_reset");
        step4(1'b0, 4'b0011, 4'b0101, 4'b1011, "w_mixed");
        step4(1'b0, 4'b1111, 4'b1111, 4'b0100, "w_toggle");

        // Random traffic on the wide instance, checked against the JK characteristic equation.
        m = 4'b0100;
        for (int i = 0; i < 24; i++) begin
            rj = 4'($urandom_range(0, 15));
            rk = 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 7) == 0);
            m  = rr ? 4'b1010 : ((rj & ~m) | (~rk & m));
            step4(rr, rj, rk, m, $sformatf("w_rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
